ncl_add_sequencer: RTL and testbench

Clocked controller that drives a WIDTH-bit dual-rail NCL ripple adder, built from minterm full-adder stages, from a synchronous system. It arbitrates NREQ binary add requests round-robin and encodes the granted operands as a DATA wavefront. It watches adder completion and output rails, captures the sum, then sequences the NULL wavefront and completion-acknowledge handshake that returns the adder to its reset-equivalent state. A watchdog flags any wavefront that fails to complete.

---
 rtl/ncl_seq_pkg.sv | 29 ++
 rtl/ncl_rr_arbiter.sv | 31 +++
 rtl/ncl_add_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ncl_add_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_seq_pkg.sv
// Shared types and dual-rail helpers for the NCL adder sequencer.
// Dual-rail pair: 00 NULL, 01 logic 0, 10 logic 1, 11 illegal.
package ncl_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DATA_WAIT = 2'd1,
      ST_NULL_WAIT = 2'd2,
      ST_ERR       = 2'd3
   } seq_state_e;

   localparam logic [1:0] NCL_NULL = 2'b00;
   localparam logic [1:0] NCL_D0   = 2'b01;
   localparam logic [1:0] NCL_D1   = 2'b10;
   localparam logic [1:0] NCL_ILL  = 2'b11;

   function automatic logic [1:0] dr_encode(input logic b);
      return b ? NCL_D1 : NCL_D0;
   endfunction

   function automatic logic dr_is_data(input logic [1:0] p);
      return (p == NCL_D0) || (p == NCL_D1);
   endfunction

   function automatic logic dr_is_null(input logic [1:0] p);
      return p == NCL_NULL;
   endfunction

endpackage

// File: rtl/ncl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after 'last', wrapping.
// Purely combinational; the caller registers the grant.
module ncl_rr_arbiter #(
   parameter int NREQ = 2,
   parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] gnt,
   output logic [LW-1:0]   gidx,
   output logic            any
);

   logic [LW-1:0] j;

   always_comb begin
      gnt  = '0;
      gidx = '0;
      any  = 1'b0;
      j    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = LW'((int'(last) + k) % NREQ);
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            gidx   = j;
         end
      end
   end

endmodule

// File: rtl/ncl_add_sequencer.sv
// Clocked controller for a dual-rail NCL ripple adder: arbitrate, DATA wave, capture, NULL wave.
// Define NCL_ADD_SYNC_EN to pass adder returns through 2-flop synchronizers.
module ncl_add_sequencer
   import ncl_seq_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  init,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   input  logic [NREQ-1:0]       c_in,
   output logic [NREQ-1:0]       gnt,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic                  cout,
   output logic                  err,
   output logic [2*WIDTH-1:0]    ncl_a,
   output logic [2*WIDTH-1:0]    ncl_b,
   output logic [1:0]            ncl_cin,
   input  logic [2*WIDTH-1:0]    ncl_sum,
   input  logic [1:0]            ncl_cout,
   input  logic [WIDTH-1:0]      ncl_ack,
   output logic                  out_comp,
   output logic [1:0]            dbg_state
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   seq_state_e         state;
   logic [LW-1:0]      last, cur;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] samp_sum;
   logic [1:0]         samp_cout;
   logic [WIDTH-1:0]   samp_ack;
   logic               data_now, null_now, ill_now, data_q, null_q;
   logic [WIDTH-1:0]   cap_sum, op_a, op_b;
   logic [2*WIDTH-1:0] enc_a, enc_b;
   logic [NREQ-1:0]    arb_gnt;
   logic [LW-1:0]      arb_idx;
   logic               arb_any;

   assign dbg_state = state;

   ncl_rr_arbiter #(.NREQ(NREQ), .LW(LW)) u_arb (
      .req  (req),
      .last (last),
      .gnt  (arb_gnt),
      .gidx (arb_idx),
      .any  (arb_any)
   );

`ifdef NCL_ADD_SYNC_EN
   logic [2*WIDTH-1:0] meta_sum;
   logic [1:0]         meta_cout;
   logic [WIDTH-1:0]   meta_ack;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         meta_sum  <= '0;
         meta_cout <= '0;
         meta_ack  <= '0;
         samp_sum  <= '0;
         samp_cout <= '0;
         samp_ack  <= '0;
      end else begin
         meta_sum  <= ncl_sum;
         meta_cout <= ncl_cout;
         meta_ack  <= ncl_ack;
         samp_sum  <= meta_sum;
         samp_cout <= meta_cout;
         samp_ack  <= meta_ack;
      end
   end
`else
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         samp_sum  <= '0;
         samp_cout <= '0;
         samp_ack  <= '0;
      end else begin
         samp_sum  <= ncl_sum;
         samp_cout <= ncl_cout;
         samp_ack  <= ncl_ack;
      end
   end
`endif

   // Completeness of the current sample; a wave only counts once seen on two samples in a row.
   always_comb begin
      data_now = dr_is_data(samp_cout) && (&samp_ack);
      null_now = dr_is_null(samp_cout) && (samp_ack == '0);
      ill_now  = (samp_cout == NCL_ILL);
      cap_sum  = '0;
      op_a     = a_in[int'(arb_idx)*WIDTH +: WIDTH];
      op_b     = b_in[int'(arb_idx)*WIDTH +: WIDTH];
      enc_a    = '0;
      enc_b    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         data_now = data_now && dr_is_data(samp_sum[2*i +: 2]);
         null_now = null_now && dr_is_null(samp_sum[2*i +: 2]);
         ill_now  = ill_now || (samp_sum[2*i +: 2] == NCL_ILL);
         cap_sum[i]      = samp_sum[2*i+1];
         enc_a[2*i +: 2] = dr_encode(op_a[i]);
         enc_b[2*i +: 2] = dr_encode(op_b[i]);
      end
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         data_q <= 1'b0;
         null_q <= 1'b0;
      end else begin
         data_q <= data_now;
         null_q <= null_now;
      end
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state    <= ST_IDLE;
         last     <= LW'(NREQ - 1);
         cur      <= '0;
         cnt      <= '0;
         gnt      <= '0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         err      <= 1'b0;
         ncl_a    <= '0;
         ncl_b    <= '0;
         ncl_cin  <= NCL_NULL;
         out_comp <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  gnt     <= arb_gnt;
                  cur     <= arb_idx;
                  ncl_a   <= enc_a;
                  ncl_b   <= enc_b;
                  ncl_cin <= dr_encode(c_in[arb_idx]);
                  cnt     <= '0;
                  state   <= ST_DATA_WAIT;
               end
            end
            ST_DATA_WAIT, ST_NULL_WAIT: begin
               if (ill_now || (cnt == CW'(TIMEOUT - 1))) begin
                  state    <= ST_ERR;
                  err      <= 1'b1;
                  gnt      <= '0;
                  ncl_a    <= '0;
                  ncl_b    <= '0;
                  ncl_cin  <= NCL_NULL;
                  out_comp <= 1'b1;
               end else if (state == ST_DATA_WAIT && data_now && data_q) begin
                  result   <= cap_sum;
                  cout     <= samp_cout[1];
                  out_comp <= 1'b1;
                  ncl_a    <= '0;
                  ncl_b    <= '0;
                  ncl_cin  <= NCL_NULL;
                  cnt      <= '0;
                  state    <= ST_NULL_WAIT;
               end else if (state == ST_NULL_WAIT && null_now && null_q) begin
                  out_comp <= 1'b0;
                  done     <= 1'b1;
                  gnt      <= '0;
                  last     <= cur;
                  state    <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // Fault is sticky: only init leaves here.
               state <= ST_ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Directed bench for ncl_add_sequencer with a behavioural 3-cycle dual-rail adder model.
module tb_ncl_add_sequencer;

   localparam int WIDTH   = 4;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  init;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_in, b_in;
   logic [NREQ-1:0]       c_in;
   logic [NREQ-1:0]       gnt;
   logic                  done, cout, err, out_comp;
   logic [WIDTH-1:0]      result;
   logic [2*WIDTH-1:0]    ncl_a, ncl_b, ncl_sum;
   logic [1:0]            ncl_cin, ncl_cout, dbg_state;
   logic [WIDTH-1:0]      ncl_ack;

   int n_cmp  = 0;
   int n_fail = 0;
   int done_cnt = 0;

   // adder model and fault knobs
   logic               manual, ill_on;
   logic [WIDTH-1:0]   ack_kill, man_ack;
   logic [2*WIDTH-1:0] man_sum;
   logic [1:0]         man_cout;
   logic [2*WIDTH-1:0] tgt_sum, ps1, ps2, ps3;
   logic [1:0]         tgt_cout, pc1, pc2, pc3;
   logic [WIDTH-1:0]   tgt_ack, pk1, pk2, pk3;
   logic               all_d;
   logic [WIDTH-1:0]   av, bv;
   logic [WIDTH:0]     s;

   always #5 clk = ~clk;

   ncl_add_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .init(init), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
      .gnt(gnt), .done(done), .result(result), .cout(cout), .err(err),
      .ncl_a(ncl_a), .ncl_b(ncl_b), .ncl_cin(ncl_cin),
      .ncl_sum(ncl_sum), .ncl_cout(ncl_cout), .ncl_ack(ncl_ack),
      .out_comp(out_comp), .dbg_state(dbg_state)
   );

   always_comb begin
      all_d    = (ncl_cin == 2'b01) || (ncl_cin == 2'b10);
      av       = '0;
      bv       = '0;
      tgt_sum  = '0;
      tgt_cout = 2'b00;
      tgt_ack  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!((ncl_a[2*i +: 2] == 2'b01) || (ncl_a[2*i +: 2] == 2'b10))) all_d = 1'b0;
         if (!((ncl_b[2*i +: 2] == 2'b01) || (ncl_b[2*i +: 2] == 2'b10))) all_d = 1'b0;
         av[i] = ncl_a[2*i+1];
         bv[i] = ncl_b[2*i+1];
      end
      s = {1'b0, av} + {1'b0, bv} + {{WIDTH{1'b0}}, ncl_cin[1]};
      if (all_d) begin
         for (int i = 0; i < WIDTH; i++) tgt_sum[2*i +: 2] = s[i] ? 2'b10 : 2'b01;
         tgt_cout = s[WIDTH] ? 2'b10 : 2'b01;
         tgt_ack  = '1;
      end
   end

   always @(posedge clk or posedge init) begin
      if (init) begin
         ps1 <= '0; ps2 <= '0; ps3 <= '0;
         pc1 <= '0; pc2 <= '0; pc3 <= '0;
         pk1 <= '0; pk2 <= '0; pk3 <= '0;
      end else begin
         ps1 <= tgt_sum;  ps2 <= ps1; ps3 <= ps2;
         pc1 <= tgt_cout; pc2 <= pc1; pc3 <= pc2;
         pk1 <= tgt_ack;  pk2 <= pk1; pk3 <= pk2;
      end
   end

   assign ncl_sum  = (manual ? man_sum : ps3) | (ill_on ? 8'b0000_1100 : 8'b0000_0000);
   assign ncl_cout = manual ? man_cout : pc3;
   assign ncl_ack  = (manual ? man_ack : pk3) & ~ack_kill;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sel: 0 any gnt, 1 done, 2 out_comp, 3 err
   task automatic wait_for(input int sel, input int maxc, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if ((sel == 0 && gnt != '0) || (sel == 1 && done === 1'b1) ||
             (sel == 2 && out_comp === 1'b1) || (sel == 3 && err === 1'b1)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pulse_init();
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      logic ok, early, bad;
      logic [NREQ-1:0] exp_g [3];
      int done_base;
      init = 1'b0; req = '0; a_in = '0; b_in = '0; c_in = '0;
      manual = 1'b0; ill_on = 1'b0; ack_kill = '0;
      man_sum = '0; man_cout = '0; man_ack = '0;
      #1 init = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_comp", 32'(out_comp), 32'd0);
      check("rst_ncl", 32'({ncl_a, ncl_b, ncl_cin}), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      init = 1'b0;
      @(negedge clk);

      // single add 5+3+0
      a_in[3:0] = 4'h5; b_in[3:0] = 4'h3; c_in = 2'b00; req = 2'b01;
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_ncl_a", 32'(ncl_a), 32'h66);
      check("t1_ncl_b", 32'(ncl_b), 32'h5A);
      check("t1_ncl_cin", 32'(ncl_cin), 32'h1);
      check("t1_out_comp0", 32'(out_comp), 32'd0);
      check("t1_state", 32'(dbg_state), 32'd1);
      wait_for(2, 20, ok);
      check("t1_capture_seen", 32'(ok), 32'd1);
      check("t1_cap_result", 32'(result), 32'h8);
      check("t1_null_wave", 32'({ncl_a, ncl_b, ncl_cin}), 32'd0);
      wait_for(1, 20, ok);
      check("t1_done_seen", 32'(ok), 32'd1);
      check("t1_result", 32'(result), 32'h8);
      check("t1_cout", 32'(cout), 32'd0);
      check("t1_gnt_clr", 32'(gnt), 32'd0);
      check("t1_out_comp", 32'(out_comp), 32'd0);
      req = '0;
      pulse_init();

      // round robin F+1+1 on both requesters
      a_in = {4'hF, 4'hF}; b_in = {4'h1, 4'h1}; c_in = 2'b11; req = 2'b11;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
      wait_for(0, 5, ok);
      check("rr_first_gnt", 32'(ok), 32'd1);
      for (int t = 0; t < 3; t++) begin
         check($sformatf("rr_gnt%0d", t), 32'(gnt), 32'(exp_g[t]));
         wait_for(1, 30, ok);
         check($sformatf("rr_done%0d", t), 32'(ok), 32'd1);
         check($sformatf("rr_result%0d", t), 32'(result), 32'h1);
         check($sformatf("rr_cout%0d", t), 32'(cout), 32'd1);
         check($sformatf("rr_gap%0d", t), 32'(gnt), 32'd0);
         if (t == 2) req = '0;
         @(negedge clk);
      end

      // requester drops req mid-operation: 2+3
      a_in[7:4] = 4'h2; b_in[7:4] = 4'h3; c_in = 2'b00; req = 2'b10;
      @(negedge clk);
      check("drop_gnt", 32'(gnt), 32'h2);
      req = '0;
      wait_for(1, 30, ok);
      check("drop_done", 32'(ok), 32'd1);
      check("drop_result", 32'(result), 32'h5);
      check("drop_cout", 32'(cout), 32'd0);

      // illegal pair on sum rail pair 1
      @(negedge clk);
      a_in[3:0] = 4'h5; b_in[3:0] = 4'h3; req = 2'b01;
      @(negedge clk);
      check("ill_gnt", 32'(gnt), 32'h1);
      req = '0; ill_on = 1'b1; done_base = done_cnt;
      wait_for(3, 3, ok);
      check("ill_err", 32'(ok), 32'd1);
      check("ill_gnt_clr", 32'(gnt), 32'd0);
      check("ill_ncl_a", 32'(ncl_a), 32'd0);
      check("ill_out_comp", 32'(out_comp), 32'd1);
      repeat (25) @(negedge clk);
      check("ill_no_done", 32'(done_cnt), 32'(done_base));
      check("ill_sticky", 32'(err), 32'd1);
      check("ill_state", 32'(dbg_state), 32'd3);
      ill_on = 1'b0;
      pulse_init();
      check("ill_init_clr", 32'(err), 32'd0);

      // watchdog: stage 2 never acknowledges
      ack_kill = 4'b0100; req = 2'b01;
      @(negedge clk);
      check("wd_gnt", 32'(gnt), 32'h1);
      req = '0; early = 1'b0;
      repeat (TIMEOUT - 1) begin
         @(negedge clk);
         if (err !== 1'b0) early = 1'b1;
      end
      check("wd_early", 32'(early), 32'd0);
      @(negedge clk);
      check("wd_err", 32'(err), 32'd1);
      check("wd_gnt_clr", 32'(gnt), 32'd0);
      check("wd_ncl_a", 32'(ncl_a), 32'd0);
      check("wd_out_comp", 32'(out_comp), 32'd1);
      repeat (10) @(negedge clk);
      check("wd_sticky", 32'(err), 32'd1);
      ack_kill = '0;
      pulse_init();

      // init during NULL_WAIT
      req = 2'b01;
      wait_for(2, 20, ok);
      check("ri_capture", 32'(ok), 32'd1);
      req = '0;
      @(negedge clk);
      check("ri_in_null_wait", 32'(dbg_state), 32'd2);
      #2 init = 1'b1;
      #1;
      check("ri_gnt", 32'(gnt), 32'd0);
      check("ri_out_comp", 32'(out_comp), 32'd0);
      check("ri_result", 32'(result), 32'd0);
      check("ri_cout", 32'(cout), 32'd0);
      check("ri_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      init = 1'b0;
      @(negedge clk);
      req = 2'b10;
      @(negedge clk);
      check("ri_next_gnt", 32'(gnt), 32'h2);
      req = '0;
      wait_for(1, 30, ok);
      check("ri_next_done", 32'(ok), 32'd1);
      check("ri_next_result", 32'(result), 32'h5);

      // glitch: one complete sample, then pair 0 drops to NULL
      manual = 1'b1;
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      check("gl_gnt", 32'(gnt), 32'h1);
      req = '0;
      man_sum = 8'b1001_1001; man_cout = 2'b10; man_ack = 4'hF;
      @(negedge clk);
      man_sum = 8'b1001_1000;
      bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (out_comp !== 1'b0) bad = 1'b1;
      end
      check("gl_no_capture", 32'(bad), 32'd0);
      check("gl_result_held", 32'(result), 32'h5);
      man_sum = 8'b1001_1001;
      wait_for(2, 10, ok);
      check("gl_capture", 32'(ok), 32'd1);
      check("gl_result", 32'(result), 32'hA);
      check("gl_cout", 32'(cout), 32'd1);
      man_sum = '0; man_cout = '0; man_ack = '0;
      wait_for(1, 20, ok);
      check("gl_done", 32'(ok), 32'd1);
      check("gl_out_comp", 32'(out_comp), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
